mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data requests win ties; each access is BUSY for MEM_LATENCY cycles, then one RESP cycle.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_gnt_dm;
  logic        r_is_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_mem_re;
  logic        r_mem_we;
  logic        r_if_ready;
  logic        r_dm_ready;
  logic        r_proto_err;

  logic        w_dm_req;

  assign w_dm_req = dm_read | dm_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_gnt_dm    <= 1'b0;
      r_is_wr     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
      r_proto_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Data belongs to the older instruction, so it is checked first.
          if (w_dm_req) begin
            r_gnt_dm    <= 1'b1;
            r_is_wr     <= dm_write;
            r_addr      <= dm_addr;
            r_wdata     <= dm_wdata;
            r_mem_re    <= ~dm_write;
            r_mem_we    <= dm_write;
            r_proto_err <= dm_read & dm_write;
            r_cnt       <= LP_CNT_LOAD;
            r_state     <= BUSY;
          end else if (if_req) begin
            r_gnt_dm <= 1'b0;
            r_is_wr  <= 1'b0;
            r_addr   <= if_addr;
            r_mem_re <= 1'b1;
            r_mem_we <= 1'b0;
            r_cnt    <= LP_CNT_LOAD;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= RESP;
            // mem_rdata is valid in this final BUSY cycle.
            if (!r_is_wr) begin
              if (r_gnt_dm) r_dm_rdata <= mem_rdata;
              else          r_if_rdata <= mem_rdata;
            end
            if (r_gnt_dm) r_dm_ready <= 1'b1;
            else          r_if_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign proto_err = r_proto_err;
  assign stall     = (if_req & ~r_if_ready) | (w_dm_req & ~r_dm_ready);

endmodule
